// File: rtl/dmem_io_pkg.sv
// Shared constants for the data-memory / memory-mapped I/O block: register
// offsets inside the I/O window, the blank display pattern and the decode helper.
package dmem_io_pkg;

  localparam int DISP_OFS = 0;
  localparam int SW_OFS   = 2;
  localparam int CYC_OFS  = 4;
  localparam int CHG_OFS  = 6;

  localparam logic [6:0] DISP_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    IO_NONE,
    IO_DISP,
    IO_SW,
    IO_CYC,
    IO_CHG
  } io_sel_e;

  // Maps a word offset inside the I/O window to the register it selects.
  function automatic io_sel_e io_sel(input logic [1:0] word_ofs);
    io_sel_e sel;
    sel = IO_NONE;
    case ({word_ofs, 1'b0})
      3'(DISP_OFS): sel = IO_DISP;
      3'(SW_OFS):   sel = IO_SW;
      3'(CYC_OFS):  sel = IO_CYC;
      3'(CHG_OFS):  sel = IO_CHG;
      default:      sel = IO_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dmem_io_ctrl_if.sv
// Processor data-memory port as seen by dmem_io_ctrl.
interface dmem_io_ctrl_if #(
    parameter int DATA_W = 16
);
    // No handshake: write commits at the rising edge when write=1; rdata is
    // combinational from addr/read, valid in the same cycle, and 0 when read=0.
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output wdata, output write, output read, input rdata);
    modport slave  (input addr, input wdata, input write, input read, output rdata);
endinterface

// File: rtl/dmem_io_ctrl_sw_debounce.sv
// One switch: 2-flop synchroniser plus optional debounce counter.
// Debounce counter present only when DMEM_IO_DEBOUNCE_EN is defined.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_sw,
    output logic o_deb,
    output logic o_change
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DMEM_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_deb;
    logic          w_diff;
    logic          w_done;

    assign w_diff = (r_sync2 != r_deb);
    assign w_done = w_diff && (r_cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else begin
            if (!w_diff || w_done) r_cnt <= '0;
            else                   r_cnt <= r_cnt + 1'b1;
            if (w_done)            r_deb <= r_sync2;
        end
    end

    assign o_deb    = r_deb;
    assign o_change = w_done;
`else
    // Debounced value is the synchroniser output; it changes at the edge
    // where the second flop takes a different value from the first.
    assign o_deb    = r_sync2;
    assign o_change = r_sync1 ^ r_sync2;
`endif

endmodule

// File: rtl/dmem_io_ctrl.sv
// Data RAM with a memory-mapped I/O window (display, switches, cycle counter,
// switch-change flag). Optional switch debounce via DMEM_IO_DEBOUNCE_EN.
module dmem_io_ctrl
    import dmem_io_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                DEPTH      = 128,
    parameter int                NUM_SW     = 2,
    parameter int                DEB_CYCLES = 4,
    parameter logic [DATA_W-1:0] IO_BASE    = 16'hFFF0
) (
    input  logic                clock,
    input  logic                reset,
    dmem_io_ctrl_if.slave       bus,
    input  logic [NUM_SW-1:0]   sw,
    output logic [6:0]          display
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [6:0]        r_disp;
    logic [DATA_W-1:0] r_cyc;
    logic              r_chg;

    logic              w_is_io;
    logic [DATA_W-2:0] w_ofs_word;
    io_sel_e           w_sel;
    logic [AW-1:0]     w_idx;
    logic [NUM_SW-1:0] w_deb;
    logic [NUM_SW-1:0] w_change;
    logic              w_wr_ram;
    logic              w_wr_disp;
    logic              w_wr_cyc;
    logic              w_wr_chg;

    assign w_is_io    = (bus.addr >= IO_BASE);
    assign w_ofs_word = bus.addr[DATA_W-1:1] - IO_BASE[DATA_W-1:1];
    // Upper address bits are dropped so RAM addresses alias modulo DEPTH.
    assign w_idx      = bus.addr[AW:1];

    always_comb begin
        w_sel = IO_NONE;
        if (w_is_io && (w_ofs_word[DATA_W-2:2] == '0)) w_sel = io_sel(w_ofs_word[1:0]);
    end

    assign w_wr_ram  = bus.write && !w_is_io;
    assign w_wr_disp = bus.write && (w_sel == IO_DISP);
    assign w_wr_cyc  = bus.write && (w_sel == IO_CYC);
    assign w_wr_chg  = bus.write && (w_sel == IO_CHG);

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_sw_debounce (
            .clock    (clock),
            .reset    (reset),
            .i_sw     (sw[g]),
            .o_deb    (w_deb[g]),
            .o_change (w_change[g])
        );
    end

    always_ff @(posedge clock) begin
        if (w_wr_ram) r_mem[w_idx] <= bus.wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp <= DISP_BLANK;
            r_cyc  <= '0;
            r_chg  <= 1'b0;
        end else begin
            if (w_wr_disp) r_disp <= bus.wdata[6:0];
            if (w_wr_cyc)  r_cyc  <= '0;
            else           r_cyc  <= r_cyc + 1'b1;
            // A switch change on the same edge as a clear keeps the flag set.
            if (|w_change)     r_chg <= 1'b1;
            else if (w_wr_chg) r_chg <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.read) begin
            if (w_is_io) begin
                case (w_sel)
                    IO_DISP: bus.rdata = DATA_W'(r_disp);
                    IO_SW:   bus.rdata = DATA_W'(w_deb);
                    IO_CYC:  bus.rdata = r_cyc;
                    IO_CHG:  bus.rdata = DATA_W'(r_chg);
                    default: bus.rdata = '0;
                endcase
            end else begin
                bus.rdata = r_mem[w_idx];
            end
        end
    end

    assign display = r_disp;

endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Directed bench for dmem_io_ctrl: RAM, display, switches, change flag, cycle counter.
module tb_dmem_io_ctrl;

    localparam int          DATA_W     = 16;
    localparam int          DEPTH      = 128;
    localparam int          NUM_SW     = 2;
    localparam int          DEB_CYCLES = 4;
    localparam logic [15:0] IO_BASE    = 16'hFFF0;
    localparam logic [15:0] A_DISP     = IO_BASE + 16'd0;
    localparam logic [15:0] A_SW       = IO_BASE + 16'd2;
    localparam logic [15:0] A_CYC      = IO_BASE + 16'd4;
    localparam logic [15:0] A_CHG      = IO_BASE + 16'd6;
`ifdef DMEM_IO_DEBOUNCE_EN
    localparam int SW_EDGE = DEB_CYCLES + 2;
`else
    localparam int SW_EDGE = 2;
`endif

    logic              clock;
    logic              reset;
    logic [NUM_SW-1:0] sw;
    logic [6:0]        display;
    int                n_checks;
    int                n_errors;

    dmem_io_ctrl_if #(.DATA_W(DATA_W)) bus ();

    dmem_io_ctrl #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .NUM_SW     (NUM_SW),
        .DEB_CYCLES (DEB_CYCLES),
        .IO_BASE    (IO_BASE)
    ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .sw      (sw),
        .display (display)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.read  = 1'b0;
        bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        bus.addr  = a;
        bus.read  = 1'b1;
        bus.write = 1'b0;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        sw        = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        tick();
        tick();
        check("display_in_reset", 16'(display), 16'h007F);
        reset = 1'b0;

        read_check("rst_disp", A_DISP, 16'h007F);
        read_check("rst_sw",   A_SW,   16'h0000);
        read_check("rst_cyc",  A_CYC,  16'h0000);
        read_check("rst_chg",  A_CHG,  16'h0000);
        check("rst_display", 16'(display), 16'h007F);

        repeat (10) tick();
        read_check("cyc_after_10", A_CYC, 16'd10);

        // RAM
        bus_write(16'h0010, 16'hBEEF);
        read_check("ram_beef", 16'h0010, 16'hBEEF);
        bus_write(16'h0010 + 16'(2 * DEPTH), 16'hCAFE);
        read_check("ram_alias", 16'h0010, 16'hCAFE);
        bus.read = 1'b0;
        #1;
        check("rdata_read0", bus.rdata, 16'h0000);
        bus.addr  = 16'h0010;
        bus.wdata = 16'h1111;
        bus.read  = 1'b1;
        bus.write = 1'b1;
        #1;
        check("ram_rw_pre_edge", bus.rdata, 16'hCAFE);
        tick();
        bus.write = 1'b0;
        read_check("ram_rw_post_edge", 16'h0010, 16'h1111);
        read_check("io_unmapped", IO_BASE + 16'd8, 16'h0000);

        // Display and read-only switch register
        bus_write(A_DISP, 16'h1234);
        check("display_34", 16'(display), 16'h0034);
        read_check("disp_read", A_DISP, 16'h0034);
        bus_write(A_SW, 16'hFFFF);
        read_check("sw_write_ignored", A_SW, 16'h0000);

        // Cycle counter load
        bus_write(A_CYC, 16'h5555);
        read_check("cyc_loaded_0", A_CYC, 16'h0000);
        tick();
        read_check("cyc_resume_1", A_CYC, 16'h0001);

        // Switch change: edge 1 is the first edge after sw moves
        sw = 2'b01;
        for (int e = 1; e <= SW_EDGE; e++) begin
            tick();
            read_check($sformatf("sw_edge%0d", e), A_SW, (e >= SW_EDGE) ? 16'h0001 : 16'h0000);
            read_check($sformatf("chg_edge%0d", e), A_CHG, (e >= SW_EDGE) ? 16'h0001 : 16'h0000);
        end
        bus_write(A_CHG, 16'h0000);
        read_check("chg_cleared", A_CHG, 16'h0000);

`ifdef DMEM_IO_DEBOUNCE_EN
        sw = 2'b00;
        repeat (3) tick();
        sw = 2'b01;
        repeat (8) tick();
        read_check("glitch_sw", A_SW, 16'h0001);
        read_check("glitch_chg", A_CHG, 16'h0000);
`endif

        // Clear racing with a debounced change
        sw = 2'b00;
        repeat (SW_EDGE - 1) tick();
        read_check("race_sw_before", A_SW, 16'h0001);
        bus.addr  = A_CHG;
        bus.read  = 1'b0;
        bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
        read_check("race_chg_set_wins", A_CHG, 16'h0001);
        read_check("race_sw_after", A_SW, 16'h0000);
        bus_write(A_CHG, 16'h0000);
        read_check("chg_clear_later", A_CHG, 16'h0000);

        // Reset mid-count
        repeat (3) tick();
        reset = 1'b1;
        #1;
        read_check("midreset_cyc", A_CYC, 16'h0000);
        read_check("midreset_disp", A_DISP, 16'h007F);
        check("midreset_display", 16'(display), 16'h007F);
        read_check("midreset_ram_kept", 16'h0010, 16'h1111);
        tick();
        reset = 1'b0;

        // Counter wrap
        repeat (65535) tick();
        read_check("cyc_ffff", A_CYC, 16'hFFFF);
        tick();
        read_check("cyc_wrap", A_CYC, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_io_ctrl.md
# dmem_io_ctrl

Parametrised data memory with a memory-mapped I/O window for the PMIPS processor family. It is the next generation of the data-memory/I-O device: data width, RAM depth and switch count are configurable. It adds switch synchronisation and debounce, a switch-change flag, and a free-running cycle counter. It sits on the processor's data-memory port and drives the board's 7-segment display.

## Interface
Parameters:
- DATA_W, 16, data/address word width
- DEPTH, 128, RAM words; power of two
- NUM_SW, 2, switch inputs; 1..DATA_W
- DEB_CYCLES, 4, debounce stability count; at least 1
- IO_BASE, 16'hFFF0, first byte address of the I/O window

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- addr  in  DATA_W  byte address; bit 0 ignored
- wdata  in  DATA_W  write data
- write  in  1  write enable
- read  in  1  read enable
- rdata  out  DATA_W  read data, combinational
- sw  in  NUM_SW  raw asynchronous switch inputs
- display  out  7  7-segment drive, active-low

## Operation
- **Address decode:** I/O when addr >= IO_BASE, otherwise RAM.
  - RAM index is addr[$clog2(DEPTH):1]; higher bits are truncated, so addresses wrap.
- **RAM:** synchronous write at the rising edge when write=1. Combinational read. Contents are not reset.
- **I/O registers:**
  - IO_BASE+0, DISP: read/write. A write stores wdata[6:0]; a read returns the value zero-extended. Drives display.
  - IO_BASE+2, SW: read-only. Returns the debounced switches zero-extended; writes are ignored.
  - IO_BASE+4, CYC: free-running counter, wraps at 2^DATA_W. A read returns the count. A write loads 0, and the count then resumes at 1 on the next edge.
  - IO_BASE+6, CHG: bit 0 is set at the edge where any debounced switch changes. A read returns the flag. A write clears it. If set and clear fall on the same edge, set wins.
  - Other I/O offsets: read 0, writes ignored.
- **rdata:** 0 when read=0.
  - With read=1 and write=1 on the same address, rdata shows the pre-edge value for that cycle.
- **Switch path, per switch:**
  - A 2-flop synchroniser feeds the debouncer.
  - The debouncer counter increments on every edge where the synchronised value differs from the debounced value. It clears on any edge where they match.
  - When the counter is at DEB_CYCLES-1 and the values still differ, the debounced value takes the synchronised value and the counter clears.
- **Reset values:**
  - DISP = 7'h7F (blank), display = 7'h7F
  - CYC = 0, CHG = 0
  - Synchronisers, debounced values and counters = 0
  - rdata follows decode, and is 0 when read=0

## Timing
- RAM and I/O reads: 0-cycle latency, combinational from addr and read.
- Writes are visible to reads after the next rising edge.
- Switch change with the macro defined, where edge 1 is the first edge sampling the new level:
  - Debounced SW updates at edge DEB_CYCLES+2.
  - CHG sets on the same edge.
- A glitch shorter than DEB_CYCLES synchronised cycles never reaches SW.
- Reset asserted mid-operation clears all registers immediately. RAM is retained.

## Configuration
- DMEM_IO_DEBOUNCE_EN defined: debounce counters are present, with the behaviour above.
- DMEM_IO_DEBOUNCE_EN undefined:
  - The debounced value equals the synchroniser output, and no counters are instantiated.
  - SW updates at edge 2; CHG sets at edge 2.

## Structure
- Shared package dmem_io_pkg holds:
  - I/O offset constants: DISP_OFS=0, SW_OFS=2, CYC_OFS=4, CHG_OFS=6
  - Display blank constant 7'h7F
- One sub-module, sw_debounce (synchroniser plus debounce for one switch), generated NUM_SW times.
- RAM, decode and I/O registers live in dmem_io_ctrl.

## Test plan
- Reset, then read DISP, SW, CYC and CHG with read=1: values are 7F, 0, 0, 0; display=7F.
- RAM write/read:
  - Write 16'hBEEF at addr 0x0010, then read 0x0010: returns BEEF.
  - Write at 0x0010+2·DEPTH: aliases to 0x0010.
  - With read=0: rdata=0.
- Display write:
  - Write 16'h1234 to IO_BASE+0: display=7'h34 after the edge, and a read returns 0x0034.
  - A write to IO_BASE+2 leaves SW unchanged.
- Switch debounce (DEB_CYCLES=4):
  - sw changes 2'b00→2'b01 and holds: SW reads 1 at edge 6 and CHG=1 at edge 6.
  - A 3-cycle pulse: no change.
  - Without the macro: update at edge 2.
- CHG clear race:
  - Write CHG in the same cycle as a debounced change: CHG stays 1.
  - A later write with no change: CHG=0.
- Cycle counter:
  - After 10 edges from reset, CYC reads 10.
  - A write to CYC gives 1 one edge later.
  - Forced count 16'hFFFF wraps to 0.
  - Asserting reset mid-count gives 0 immediately.
